modulo_condicionador_disparo: RTL
=================================

// Module: modulo_condicionador_disparo
// PURPOSE
// - Upstream stage of the game datapath. Turns the raw fire/place pushbutton and the hh1/hh2 switches into clean, single-cycle commands.
// - Debounces the button and validates the row/column coordinate against the 7x5 board.
// - Emits one place pulse (position mode) or one shot pulse (attack mode), each with latched coordinates.
// - Downstream consumers: position-matrix register load and attack-matrix cell clock demux.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  clocks the synced button must stay stable to accept a press or release
// CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// ROWS             7       board rows; valid row = 0..ROWS-1
// COLS             5       board columns; valid col = 0..COLS-1
// MAX_SHOTS        35      saturation value of shot_count
// PORTS
// clk          in   1  system clock
// clr_n        in   1  synchronous reset, active-low
// button_raw   in   1  raw pushbutton, active-low, asynchronous to clk
// hh1          in   2  mode: 01 = position, 10 = attack, 00/11 = idle
// hh2          in   6  coordinate: [5:3] = row, [2:0] = col
// place_pulse  out  1  one-cycle strobe: accepted press in position mode
// shot_pulse   out  1  one-cycle strobe: accepted, valid shot in attack mode
// shot_reject  out  1  one-cycle strobe: attack press rejected (out of range or repeat)
// cmd_row      out  3  row latched at the accepted press
// cmd_col      out  3  col latched at the accepted press
// shot_count   out  6  number of accepted shots, saturates at MAX_SHOTS
// busy         out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset: while clr_n=0 at a clk edge, all outputs go to 0, FSM goes to IDLE, debounce counter and history clear.
//   - Reset mid-press drops the press with no pulse.
//   - A button still held when reset releases must first be seen released before another press is accepted.
// - Synchroniser: button_raw passes through 2 flops; btn = inverted sync output, so 1 = pressed.
// - FSM states and transitions:
//   - IDLE -> PRESS_DB when btn=1.
//   - PRESS_DB: counter increments each clock while btn=1.
//     - btn=0 -> IDLE with counter cleared.
//     - counter = DEBOUNCE_CYCLES-1 -> FIRE.
//   - FIRE: exactly one cycle, then -> HELD.
//     - On entry, cmd_row/cmd_col are loaded from hh2 and hh1 is sampled.
//     - Strobes are registered and asserted during the FIRE cycle only.
//   - HELD: -> REL_DB when btn=0.
//   - REL_DB: counter increments each clock while btn=0.
//     - btn=1 -> HELD.
//     - counter = DEBOUNCE_CYCLES-1 -> IDLE.
// - Latency: a clean press produces its strobe 2 + DEBOUNCE_CYCLES + 1 clocks after button_raw falls.
// - Exactly one strobe per physical press. Holding the button never repeats.
// - Validity: valid = (row < ROWS) && (col < COLS), with unsigned 3-bit compares.
// - Strobe selection in FIRE:
//   - hh1=01: place_pulse=1, regardless of valid.
//   - hh1=10 and valid and not repeat: shot_pulse=1, shot_count += 1 (saturating).
//   - hh1=10 and (!valid or repeat): shot_reject=1, count unchanged.
//   - hh1=00/11: no strobe, but cmd_row/cmd_col are still updated.
// - At most one of place_pulse, shot_pulse, shot_reject is high in any cycle.
// - cmd_row/cmd_col hold their value until the next FIRE.
// - hh1/hh2 changes outside FIRE have no effect.
// - shot_count stays at MAX_SHOTS when saturated, and further valid shots still pulse.
// CONFIGURATION
// - SHOT_HISTORY_EN defined:
//   - A ROWS*COLS-bit register marks every cell that has received a shot_pulse (bit index = row*COLS + col).
//   - An attack press on a marked cell gives shot_reject, and shot_count does not increment.
//   - History clears only on reset.
// - SHOT_HISTORY_EN undefined:
//   - No history register; repeat = 0.
//   - Every in-range attack press gives shot_pulse.
// TESTING (use DEBOUNCE_CYCLES=4)
// - Reset, then hold button_raw=0 for 20 clk, hh1=10, hh2=6'b010_011 -> one shot_pulse 7 clk after the fall; cmd_row=2, cmd_col=3, shot_count=1.
// - Bounce: button_raw toggles every 2 clk for 12 clk, then stays high -> no strobe; busy returns to 0.
// - hh1=10, hh2=6'b111_000 (row 7), clean press -> shot_reject for 1 clk; shot_count unchanged.
// - hh1=01, hh2=6'b000_110 (col 6), clean press -> place_pulse=1, shot_pulse=0, cmd_col=6.
// - SHOT_HISTORY_EN: two clean presses on row 1, col 1 in attack mode -> first gives shot_pulse, second gives shot_reject, shot_count=1.
//   - Without the macro: two shot_pulse, shot_count=2.
// - Assert clr_n=0 during PRESS_DB with button held, release clr_n while still held -> no strobe until the button is released and pressed again.

Source files
------------

// File: rtl/modulo_condicionador_disparo.sv
// Fire/place button conditioner: synchroniser, press/release debounce FSM, coordinate validation.
// Optional macro SHOT_HISTORY_EN adds a per-cell shot history that rejects repeated shots.
module modulo_condicionador_disparo #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ROWS            = 7,
    parameter int COLS            = 5,
    parameter int MAX_SHOTS       = 35
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       button_raw,
    input  logic [1:0] hh1,
    input  logic [5:0] hh2,
    output logic       place_pulse,
    output logic       shot_pulse,
    output logic       shot_reject,
    output logic [2:0] cmd_row,
    output logic [2:0] cmd_col,
    output logic [5:0] shot_count,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, PRESS_DB, FIRE, HELD, REL_DB} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]       SHOT_MAX  = 6'(MAX_SHOTS);
    localparam logic [1:0]       MODE_POS  = 2'b01;
    localparam logic [1:0]       MODE_ATK  = 2'b10;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_place;
    logic             r_shot;
    logic             r_reject;
    logic [2:0]       r_row;
    logic [2:0]       r_col;
    logic [5:0]       r_count;
    logic             r_busy;

    logic       w_btn;
    logic [2:0] w_row;
    logic [2:0] w_col;
    logic       w_valid;
    logic       w_repeat;
    logic       w_fire_now;
    logic       w_shot_ok;

    assign w_btn      = ~r_sync[1];
    assign w_row      = hh2[5:3];
    assign w_col      = hh2[2:0];
    assign w_valid    = ({1'b0, w_row} < 4'(ROWS)) && ({1'b0, w_col} < 4'(COLS));
    assign w_fire_now = (r_state == PRESS_DB) && w_btn && (r_cnt == CNT_LAST);
    assign w_shot_ok  = (hh1 == MODE_ATK) && w_valid && !w_repeat;

`ifdef SHOT_HISTORY_EN
    localparam int HIST_W = ROWS * COLS;

    logic [HIST_W-1:0] r_history;
    logic [7:0]        w_idx;

    assign w_idx    = 8'(w_row) * 8'(COLS) + 8'(w_col);
    // Shift-and-mask keeps the lookup in range even when the coordinate is invalid
    assign w_repeat = w_valid && |(r_history & (HIST_W'(1) << w_idx));

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_history <= '0;
        end else if (w_fire_now && w_shot_ok) begin
            r_history <= r_history | (HIST_W'(1) << w_idx);
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            // Sync flops reset to "pressed" so a button held through reset never arms
            r_sync   <= '0;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_armed  <= 1'b0;
            r_place  <= 1'b0;
            r_shot   <= 1'b0;
            r_reject <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], button_raw};
            r_place  <= 1'b0;
            r_shot   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_btn) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= PRESS_DB;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!w_btn) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= FIRE;
                        r_cnt   <= '0;
                        r_row   <= w_row;
                        r_col   <= w_col;
                        if (hh1 == MODE_POS) begin
                            r_place <= 1'b1;
                        end else if (hh1 == MODE_ATK) begin
                            if (w_shot_ok) begin
                                r_shot <= 1'b1;
                                if (r_count != SHOT_MAX) r_count <= r_count + 6'd1;
                            end else begin
                                r_reject <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                FIRE: begin
                    r_state <= HELD;
                end
                HELD: begin
                    if (!w_btn) begin
                        r_state <= REL_DB;
                        r_cnt   <= '0;
                    end
                end
                REL_DB: begin
                    if (w_btn) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign place_pulse = r_place;
    assign shot_pulse  = r_shot;
    assign shot_reject = r_reject;
    assign cmd_row     = r_row;
    assign cmd_col     = r_col;
    assign shot_count  = r_count;
    assign busy        = r_busy;

endmodule
